// File: rtl/ft601_device_model_pkg.sv
// Shared types and defaults for the FT601 chip-side bus model.
package ft601_device_model_pkg;

  localparam int usb_packet_width  = 32;
  localparam int ft601_be_width    = 4;
  localparam int ft601_model_depth = 16;

  // One bus beat as stored in either direction buffer.
  typedef struct packed {
    logic [usb_packet_width-1:0] data;
    logic [ft601_be_width-1:0]   be;
  } ft601_word_t;

endpackage

// File: rtl/ft601_device_model_if.sv
// 245-synchronous FIFO bus between the FPGA controller (master) and the chip (slave).
interface ft601_device_model_if #(parameter int DATA_W = 32);
  import ft601_device_model_pkg::*;

  logic [DATA_W-1:0]         usb_data_to_dev;
  logic [ft601_be_width-1:0] usb_be_to_dev;
  logic [DATA_W-1:0]         usb_data_from_dev;
  logic [ft601_be_width-1:0] usb_be_from_dev;
  logic                      usb_dev_drive;
  logic                      usb_tx_full;
  logic                      usb_rx_empty;
  logic                      usb_wren_l;
  logic                      usb_rden_l;
  logic                      usb_outen_l;
  logic                      usb_rst_l;

  modport master (
    output usb_data_to_dev, usb_be_to_dev, usb_wren_l, usb_rden_l, usb_outen_l, usb_rst_l,
    input  usb_data_from_dev, usb_be_from_dev, usb_dev_drive, usb_tx_full, usb_rx_empty
  );

  modport slave (
    input  usb_data_to_dev, usb_be_to_dev, usb_wren_l, usb_rden_l, usb_outen_l, usb_rst_l,
    output usb_data_from_dev, usb_be_from_dev, usb_dev_drive, usb_tx_full, usb_rx_empty
  );

endinterface

// File: rtl/ft601_model_fifo.sv
// First-word-fall-through FIFO of bus beats with a synchronous flush.
// Pointers carry one extra MSB so full and empty are distinguishable.
module ft601_model_fifo
  import ft601_device_model_pkg::*;
#(
  parameter int DEPTH = ft601_model_depth
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     flush,
  input  logic                     push,
  input  ft601_word_t              wdata,
  input  logic                     pop,
  output ft601_word_t              rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  ft601_word_t   mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush returns both pointers to zero.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty gates every consumer.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ft601_device_model.sv
// Chip-side responder for the FT601 245-synchronous FIFO bus.
// RB carries host words toward the FPGA, WB sinks words the FPGA writes.
module ft601_device_model
  import ft601_device_model_pkg::*;
#(
  parameter int DEPTH       = ft601_model_depth,
  parameter int FULL_MARGIN = 2,
  parameter int DATA_W      = usb_packet_width
) (
  input  logic                      clk,
  input  logic                      rst_l,
  ft601_device_model_if.slave       bus,
  input  logic [DATA_W-1:0]         host_tx_data,
  input  logic [ft601_be_width-1:0] host_tx_be,
  input  logic                      host_tx_valid,
  output logic                      host_tx_ready,
  output logic [DATA_W-1:0]         host_rx_data,
  output logic [ft601_be_width-1:0] host_rx_be,
  output logic                      host_rx_valid,
  input  logic                      host_rx_ready,
  output logic                      overrun,
  output logic                      underrun,
  output logic                      contention
);

  localparam int CW = $clog2(DEPTH) + 1;

  ft601_word_t   rb_head;
  ft601_word_t   wb_head;
  logic [CW-1:0] rb_count;
  logic [CW-1:0] wb_count;
  logic [CW-1:0] rb_count_next;
  logic [CW-1:0] wb_count_next;
  logic          rb_full, rb_empty, wb_full, wb_empty;
  logic          rb_push, rb_pop, wb_push, wb_pop;
  logic          flush, rd_req, contend_now;
  logic          rx_empty_q, tx_full_q;

  assign flush       = ~bus.usb_rst_l;
  assign rd_req      = ~bus.usb_outen_l & ~bus.usb_rden_l;
  assign contend_now = ~bus.usb_outen_l & ~bus.usb_wren_l;

  assign host_tx_ready = ~rb_full & bus.usb_rst_l;
  assign rb_push       = host_tx_valid & host_tx_ready;
  assign rb_pop        = rd_req & ~rb_empty;

  // A write colliding with output-enable is not captured.
  assign wb_push       = ~bus.usb_wren_l & bus.usb_outen_l & ~wb_full;
  assign host_rx_valid = ~wb_empty;
  assign wb_pop        = host_rx_valid & host_rx_ready;

  ft601_model_fifo #(.DEPTH(DEPTH)) u_rb (
    .clk   (clk),
    .rst_l (rst_l),
    .flush (flush),
    .push  (rb_push),
    .wdata ('{data: host_tx_data, be: host_tx_be}),
    .pop   (rb_pop),
    .rdata (rb_head),
    .count (rb_count),
    .full  (rb_full),
    .empty (rb_empty)
  );

  ft601_model_fifo #(.DEPTH(DEPTH)) u_wb (
    .clk   (clk),
    .rst_l (rst_l),
    .flush (flush),
    .push  (wb_push),
    .wdata ('{data: bus.usb_data_to_dev, be: bus.usb_be_to_dev}),
    .pop   (wb_pop),
    .rdata (wb_head),
    .count (wb_count),
    .full  (wb_full),
    .empty (wb_empty)
  );

  // Occupancy after the coming edge, used for the registered status flags.
  always_comb begin
    rb_count_next = rb_count + CW'(rb_push) - CW'(rb_pop);
    wb_count_next = wb_count + CW'(wb_push) - CW'(wb_pop);
  end

  // Registered bus status and sticky error flags.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rx_empty_q <= 1'b1;
      tx_full_q  <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
      contention <= 1'b0;
    end else if (flush) begin
      rx_empty_q <= 1'b1;
      tx_full_q  <= 1'b1;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
      contention <= 1'b0;
    end else begin
      rx_empty_q <= (rb_count_next == '0);
      tx_full_q  <= (wb_count_next >= CW'(DEPTH - FULL_MARGIN));
      if (~bus.usb_wren_l & tx_full_q) overrun    <= 1'b1;
      if (rd_req & rb_empty)           underrun   <= 1'b1;
      if (contend_now)                 contention <= 1'b1;
    end
  end

  // Chip reset forces the bus to look unavailable for as long as it is held.
  assign bus.usb_rx_empty = rx_empty_q | flush;
  assign bus.usb_tx_full  = tx_full_q | flush;

  // Drive enable follows output-enable with no latency, but never in reset.
  assign bus.usb_dev_drive     = ~bus.usb_outen_l & rst_l;
  assign bus.usb_data_from_dev = rb_empty ? '0 : rb_head.data;
  assign bus.usb_be_from_dev   = rb_empty ? '0 : rb_head.be;
  assign host_rx_data          = wb_empty ? '0 : wb_head.data;
  assign host_rx_be            = wb_empty ? '0 : wb_head.be;

endmodule

// File: tb/tb_ft601_device_model.sv
// Self-checking bench for the FT601 chip-side model.
module tb_ft601_device_model;
  import ft601_device_model_pkg::*;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [31:0] host_tx_data;
  logic [3:0]  host_tx_be;
  logic        host_tx_valid;
  logic        host_tx_ready;
  logic [31:0] host_rx_data;
  logic [3:0]  host_rx_be;
  logic        host_rx_valid;
  logic        host_rx_ready;
  logic        overrun, underrun, contention;

  int checks = 0;
  int failures = 0;

  logic [35:0] rb_q[$];
  logic [35:0] wb_q[$];

  ft601_device_model_if #(.DATA_W(32)) bus ();

  ft601_device_model #(.DEPTH(16), .FULL_MARGIN(2), .DATA_W(32)) dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .bus           (bus),
    .host_tx_data  (host_tx_data),
    .host_tx_be    (host_tx_be),
    .host_tx_valid (host_tx_valid),
    .host_tx_ready (host_tx_ready),
    .host_rx_data  (host_rx_data),
    .host_rx_be    (host_rx_be),
    .host_rx_valid (host_rx_valid),
    .host_rx_ready (host_rx_ready),
    .overrun       (overrun),
    .underrun      (underrun),
    .contention    (contention)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        outen_l, rden_l, wren_l;
    logic [31:0] data;
    int          cycles;
    logic        exp_drive, exp_rx_empty, exp_underrun, exp_contention, exp_rx_valid;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.usb_outen_l     = 1'b1;
    bus.usb_rden_l      = 1'b1;
    bus.usb_wren_l      = 1'b1;
    bus.usb_rst_l       = 1'b1;
    bus.usb_data_to_dev = '0;
    bus.usb_be_to_dev   = '0;
    host_tx_valid       = 1'b0;
    host_tx_data        = '0;
    host_tx_be          = '0;
    host_rx_ready       = 1'b0;
  endtask

  task automatic chip_reset();
    bus.usb_rst_l = 1'b0;
    step();
    bus.usb_rst_l = 1'b1;
    step();
    rb_q.delete();
    wb_q.delete();
  endtask

  task automatic host_push(input logic [31:0] d, input logic [3:0] be);
    host_tx_valid = 1'b1;
    host_tx_data  = d;
    host_tx_be    = be;
    #1;
    check("host_tx_ready", host_tx_ready, 1'b1);
    rb_q.push_back({be, d});
    step();
    host_tx_valid = 1'b0;
  endtask

  task automatic ctrl_write(input logic [31:0] d, input logic [3:0] be, input logic stored);
    bus.usb_wren_l      = 1'b0;
    bus.usb_data_to_dev = d;
    bus.usb_be_to_dev   = be;
    if (stored) wb_q.push_back({be, d});
    step();
    bus.usb_wren_l = 1'b1;
  endtask

  task automatic ctrl_read(input int n);
    logic [35:0] e;
    bus.usb_outen_l = 1'b0;
    bus.usb_rden_l  = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      if (rb_q.size() == 0) begin
        check("rb_scoreboard_nonempty", 1'b0, 1'b1);
        e = '0;
      end else begin
        e = rb_q.pop_front();
      end
      check("rd_data", bus.usb_data_from_dev, e[31:0]);
      check("rd_be", bus.usb_be_from_dev, e[35:32]);
      step();
    end
    bus.usb_rden_l  = 1'b1;
    bus.usb_outen_l = 1'b1;
  endtask

  task automatic host_drain(input int n);
    logic [35:0] e;
    host_rx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      check("host_rx_valid", host_rx_valid, 1'b1);
      if (wb_q.size() == 0) begin
        check("wb_scoreboard_nonempty", 1'b0, 1'b1);
        e = '0;
      end else begin
        e = wb_q.pop_front();
      end
      check("host_rx_data", host_rx_data, e[31:0]);
      check("host_rx_be", host_rx_be, e[35:32]);
      step();
    end
    host_rx_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"rd_empty",  1'b0, 1'b0, 1'b1, 32'h0,        2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"contend",   1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"rd_no_oe",  1'b1, 1'b0, 1'b1, 32'h0,        2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{"plain_wr",  1'b1, 1'b1, 1'b0, 32'h12345678, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    idle();
    rst_l = 1'b0;
    step(); step();
    check("rst_rx_empty", bus.usb_rx_empty, 1'b1);
    check("rst_tx_full", bus.usb_tx_full, 1'b0);
    check("rst_dev_drive", bus.usb_dev_drive, 1'b0);
    check("rst_rx_valid", host_rx_valid, 1'b0);
    check("rst_tx_ready", host_tx_ready, 1'b1);
    check("rst_flags", {overrun, underrun, contention}, 3'b000);
    check("rst_rd_data", bus.usb_data_from_dev, 32'h0);
    rst_l = 1'b1;
    step();

    // Ordered read of four host words
    for (int i = 1; i <= 4; i++) host_push(32'hA0000000 + 32'(i), 4'hF);
    check("t1_rx_empty_filled", bus.usb_rx_empty, 1'b0);
    ctrl_read(4);
    check("t1_rx_empty_after", bus.usb_rx_empty, 1'b1);
    check("t1_underrun", underrun, 1'b0);

    // Fill WB past the full threshold into the margin, then drop one
    chip_reset();
    for (int i = 0; i < 14; i++) begin
      ctrl_write(32'hB0000000 + 32'(i), 4'(i), 1'b1);
      if (i == 12) check("t2_tx_full_13", bus.usb_tx_full, 1'b0);
    end
    check("t2_tx_full_14", bus.usb_tx_full, 1'b1);
    check("t2_overrun_14", overrun, 1'b0);
    ctrl_write(32'hB000000E, 4'hE, 1'b1);
    ctrl_write(32'hB000000F, 4'hF, 1'b1);
    check("t2_overrun_16", overrun, 1'b1);
    ctrl_write(32'hBADBAD17, 4'h7, 1'b0);
    host_drain(16);
    check("t2_drained", host_rx_valid, 1'b0);
    check("t2_tx_full_drained", bus.usb_tx_full, 1'b0);

    // Single-scenario table: each row starts from a chip-reset state
    for (int v = 0; v < 4; v++) begin
      chip_reset();
      bus.usb_outen_l     = vecs[v].outen_l;
      bus.usb_rden_l      = vecs[v].rden_l;
      bus.usb_wren_l      = vecs[v].wren_l;
      bus.usb_data_to_dev = vecs[v].data;
      bus.usb_be_to_dev   = 4'hF;
      #1;
      check({vecs[v].name, "_drive"}, bus.usb_dev_drive, vecs[v].exp_drive);
      for (int c = 0; c < vecs[v].cycles; c++) step();
      idle();
      #1;
      check({vecs[v].name, "_rx_empty"}, bus.usb_rx_empty, vecs[v].exp_rx_empty);
      check({vecs[v].name, "_underrun"}, underrun, vecs[v].exp_underrun);
      check({vecs[v].name, "_contention"}, contention, vecs[v].exp_contention);
      check({vecs[v].name, "_rx_valid"}, host_rx_valid, vecs[v].exp_rx_valid);
      if (vecs[v].exp_rx_valid) check({vecs[v].name, "_rx_data"}, host_rx_data, vecs[v].data);
    end

    // Chip reset flush with both buffers occupied and a sticky flag set
    chip_reset();
    for (int i = 0; i < 3; i++) host_push(32'hC0000000 + 32'(i), 4'h3);
    for (int i = 0; i < 5; i++) ctrl_write(32'hD0000000 + 32'(i), 4'h5, 1'b1);
    bus.usb_outen_l = 1'b0;
    bus.usb_wren_l  = 1'b0;
    step();
    idle();
    check("t5_contention_set", contention, 1'b1);
    bus.usb_rst_l = 1'b0;
    #1;
    check("t5_hold_rx_empty", bus.usb_rx_empty, 1'b1);
    check("t5_hold_tx_full", bus.usb_tx_full, 1'b1);
    check("t5_hold_tx_ready", host_tx_ready, 1'b0);
    step();
    bus.usb_rst_l = 1'b1;
    step();
    rb_q.delete();
    wb_q.delete();
    check("t5_rx_empty", bus.usb_rx_empty, 1'b1);
    check("t5_tx_full", bus.usb_tx_full, 1'b0);
    check("t5_rx_valid", host_rx_valid, 1'b0);
    check("t5_flags", {overrun, underrun, contention}, 3'b000);
    check("t5_tx_ready", host_tx_ready, 1'b1);

    // Asynchronous reset in the middle of a read burst
    for (int i = 0; i < 3; i++) host_push(32'hE0000000 + 32'(i), 4'hC);
    bus.usb_outen_l = 1'b0;
    bus.usb_wren_l  = 1'b0;
    step();
    bus.usb_wren_l  = 1'b1;
    bus.usb_rden_l  = 1'b0;
    step();
    #2;
    rst_l = 1'b0;
    #1;
    check("t5a_dev_drive", bus.usb_dev_drive, 1'b0);
    check("t5a_rx_empty", bus.usb_rx_empty, 1'b1);
    check("t5a_tx_full", bus.usb_tx_full, 1'b0);
    check("t5a_rd_data", bus.usb_data_from_dev, 32'h0);
    check("t5a_flags", {overrun, underrun, contention}, 3'b000);
    check("t5a_tx_ready", host_tx_ready, 1'b1);
    idle();
    step();
    rst_l = 1'b1;
    step();
    rb_q.delete();
    wb_q.delete();

    // Streaming push and pop every cycle across two pointer wraps
    host_push(32'hF0000000, 4'h1);
    host_push(32'hF0000001, 4'h2);
    bus.usb_outen_l = 1'b0;
    bus.usb_rden_l  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic [35:0] e;
      host_tx_valid = 1'b1;
      host_tx_data  = 32'hF0000002 + 32'(i);
      host_tx_be    = 4'(i + 3);
      #1;
      e = rb_q.pop_front();
      check("t6_data", bus.usb_data_from_dev, e[31:0]);
      check("t6_be", bus.usb_be_from_dev, e[35:32]);
      check("t6_rx_empty", bus.usb_rx_empty, 1'b0);
      rb_q.push_back({host_tx_be, host_tx_data});
      step();
    end
    host_tx_valid = 1'b0;
    bus.usb_rden_l  = 1'b1;
    bus.usb_outen_l = 1'b1;
    ctrl_read(2);
    check("t6_empty_after", bus.usb_rx_empty, 1'b1);
    check("t6_flags", {overrun, underrun, contention}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ft601_device_model.md
Name: ft601_device_model

Overview:
- Synthesizable, cycle-accurate model of the FT601 chip side of the 245-synchronous FIFO bus, i.e. the responder to ft601_controller.
- Drives usb_tx_full and usb_rx_empty, and drives usb_data / usb_be toward the controller during reads.
- Sinks words the controller writes.
- Exposes host-side valid/ready streams, so a bench or an on-FPGA loopback build can exercise the controller and lycan datapath without real USB hardware.

Parameters:
- DEPTH, 16: words per direction buffer; power of two, minimum 4.
- FULL_MARGIN, 2: free slots still remaining in the write buffer when usb_tx_full asserts; absorbs controller wren pipeline latency.
- DATA_W, usb_packet_width (32): bus width.

Ports:
- clk  in  1  bus clock, common to controller and model.
- rst_l  in  1  asynchronous, active-low reset.
- usb_data_to_dev  in  DATA_W  bus value driven by the controller (write data).
- usb_be_to_dev  in  4  byte enables driven by the controller.
- usb_data_from_dev  out  DATA_W  read data toward the controller.
- usb_be_from_dev  out  4  read byte enables.
- usb_dev_drive  out  1  1 = model drives data/be (tristate enable for the bus wrapper).
- usb_tx_full  out  1  1 = no space for controller writes.
- usb_rx_empty  out  1  1 = no read data available.
- usb_wren_l  in  1  controller write strobe, active low.
- usb_rden_l  in  1  controller read strobe, active low.
- usb_outen_l  in  1  controller output-enable request, active low.
- usb_rst_l  in  1  chip reset from controller, active low.
- host_tx_data  in  DATA_W  word to deliver toward FPGA (host→FPGA).
- host_tx_be  in  4  byte enables for host_tx_data.
- host_tx_valid  in  1  host word valid.
- host_tx_ready  out  1  model accepts host word this cycle.
- host_rx_data  out  DATA_W  word captured from controller.
- host_rx_be  out  4  its byte enables.
- host_rx_valid  out  1  captured word available.
- host_rx_ready  in  1  host consumes word.
- overrun  out  1  sticky: write attempted while usb_tx_full = 1.
- underrun  out  1  sticky: read attempted while usb_rx_empty = 1.
- contention  out  1  sticky: usb_outen_l = 0 and usb_wren_l = 0 in the same cycle.

Behaviour:
- Reset (rst_l = 0): both buffers empty; usb_rx_empty = 1; usb_tx_full = 0; usb_dev_drive = 0; host_rx_valid = 0; host_tx_ready = 1; sticky flags = 0; data/be outputs = 0.
- Chip reset: usb_rst_l = 0, sampled at clk, flushes both buffers and clears sticky flags synchronously. While low: usb_rx_empty = 1, usb_tx_full = 1, host_tx_ready = 0. This is the only way to clear the sticky flags other than rst_l.
- Read path (host→FPGA): first-word-fall-through buffer RB.
  - usb_data_from_dev / usb_be_from_dev = RB head (combinational).
  - usb_dev_drive = ~usb_outen_l, combinational, no added latency.
  - Pop on a rising edge with usb_outen_l = 0, usb_rden_l = 0 and RB non-empty. The next word is presented in the following cycle.
  - usb_rx_empty is registered: equals (RB count after this edge == 0). The controller sees empty in the cycle after the last pop.
  - rden_l = 0 while RB is empty: no pop; underrun set.
- Host push into RB: host_tx_ready = RB not full. A push occurs when host_tx_valid & host_tx_ready.
  - Push and pop in the same cycle: count unchanged.
  - Push into an empty RB: usb_rx_empty deasserts on the next edge.
- Write path (FPGA→host): buffer WB.
  - Capture usb_data_to_dev / usb_be_to_dev on a rising edge with usb_wren_l = 0 and WB count < DEPTH.
  - usb_tx_full is registered: 1 when WB count after the edge ≥ DEPTH − FULL_MARGIN.
  - Write with usb_tx_full = 1: sets overrun. The word is still stored if physical space remains (margin slots); it is dropped only at count == DEPTH.
- Host pop from WB: host_rx_valid = WB not empty, FWFT. A pop occurs when host_rx_valid & host_rx_ready. Simultaneous capture and pop leaves count unchanged.
- Contention: usb_outen_l = 0 with usb_wren_l = 0 sets contention. No write is captured that cycle; the read side still behaves normally.
- rden_l = 0 with outen_l = 1: ignored, no pop, no flag.
- Pointers: log2(DEPTH)+1 bits, wrap-around by natural overflow. The MSB distinguishes full from empty.

Decomposition:
- Add to lycan_globals:
  - ft601_be_width = 4
  - ft601_model_depth default
  - a packed struct ft601_word_t {data, be} used for both buffers.
- One natural sub-module: ft601_model_fifo.
  - Synchronous FWFT FIFO of ft601_word_t, parameterized on DEPTH.
  - Outputs count, full, empty.
  - Asynchronous rst_l plus synchronous flush input.
  - Instantiated twice (RB, WB).

Test Plan:
1. Host pushes 0xA0000001..0xA0000004 (be = 0xF); controller holds outen_l = 0, then rden_l = 0 for 4 cycles → words appear in order, one per cycle; usb_rx_empty = 1 the cycle after the 4th pop; underrun = 0.
2. Controller writes 14 words with host_rx_ready = 0 (DEPTH 16, margin 2) → usb_tx_full = 1 after the 14th edge. Two more writes are stored with overrun = 1. A 17th write is dropped. Host then drains exactly 16 words, values intact.
3. Empty RB, outen_l = 0, rden_l = 0 for 2 cycles → no pop; underrun = 1; usb_rx_empty stays 1.
4. outen_l = 0 and wren_l = 0 together with data 0xDEADBEEF → contention = 1; WB count unchanged; usb_dev_drive = 1.
5. RB holds 3 words and WB holds 5 words; pulse usb_rst_l low for 1 cycle → both empty; rx_empty = 1; tx_full = 0 after release; sticky flags cleared. Repeat the scenario with rst_l asserted mid-read → all outputs at reset values asynchronously.
6. Simultaneous host push and controller pop every cycle for 40 cycles (wraps pointers twice) → ordering preserved; RB count constant; no flags.
